// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the post-retire store commit buffer: entry layout, drain FSM
// states and the store-size legality helper.
package store_commit_buffer_pkg;

  localparam int SB_ADDR_W = 64;

  typedef logic [63:0] MemoryWord;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    MemoryWord            wdata;
    logic [7:0]           wstrb;
  } store_buf_entry_t;

  typedef enum logic {IDLE, REQ} sbuf_state_t;

  function automatic logic size_legal(input logic [3:0] s);
    return s inside {4'd1, 4'd2, 4'd4, 4'd8};
  endfunction

endpackage

// File: rtl/sbuf_lane_shift.sv
// Places a right-justified store into its doubleword byte lanes and flags
// illegal sizes and naturally-misaligned addresses.
module sbuf_lane_shift
  import store_commit_buffer_pkg::*;
(
  input  logic [3:0] size,
  input  logic [2:0] off,
  input  MemoryWord  data,
  output logic [7:0] wstrb,
  output MemoryWord  wdata,
  output logic       legal,
  output logic       misalign
);

  logic [15:0] mask;

  always_comb begin
    legal    = size_legal(size);
    // 16-bit intermediate so a size of 8 yields 0xFF rather than overflowing
    mask     = (16'd1 << size) - 16'd1;
    wstrb    = 8'(mask << off);
    wdata    = data << {off, 3'b000};
    misalign = legal && ((off & 3'(size - 4'd1)) != 3'd0);
  end

endmodule

// File: rtl/store_commit_buffer.sv
// In-order store buffer between retire and the D-cache write port: queues
// committed stores, drains them via req/ack, and reports load/fence status.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  MemoryWord         st_data,
  input  logic [3:0]        st_size,
  output logic              retire_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output MemoryWord         mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_conflict,
  input  logic              fence_req,
  output logic              fence_done,
  output logic              misalign_err
);

  localparam int PTR_W = $clog2(DEPTH);

  store_buf_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count, count_nxt;
  sbuf_state_t      state, state_nxt;

  logic [7:0] sh_wstrb;
  MemoryWord  sh_wdata;
  logic       sh_legal, sh_misalign;
  logic       offered, push, pop;

  sbuf_lane_shift u_lane_shift (
    .size     (st_size),
    .off      (st_addr[2:0]),
    .data     (st_data),
    .wstrb    (sh_wstrb),
    .wdata    (sh_wdata),
    .legal    (sh_legal),
    .misalign (sh_misalign)
  );

  assign offered   = st_valid && !retire_stall && sh_legal;
  assign push      = offered && !sh_misalign;
  assign pop       = (state == REQ) && mem_ack;
  assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (count != '0) state_nxt = REQ;
      // remain in REQ while anything is left so drains run back-to-back
      REQ:  if (pop && count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      entries      <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= IDLE;
      retire_stall <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      if (push) begin
        entries[tail] <= '{valid: 1'b1,
                           addr:  SB_ADDR_W'({st_addr[ADDR_W-1:3], 3'b000}),
                           wdata: sh_wdata,
                           wstrb: sh_wstrb};
        tail          <= tail + PTR_W'(1);
      end
      count        <= count_nxt;
      state        <= state_nxt;
      retire_stall <= (count_nxt == (PTR_W+1)'(DEPTH));
      misalign_err <= offered && sh_misalign;
    end
  end

  // Outputs gated by mem_req so the port idles at zero outside a request
  assign mem_req    = (state == REQ);
  assign mem_addr   = mem_req ? entries[head].addr[ADDR_W-1:0] : '0;
  assign mem_wdata  = mem_req ? entries[head].wdata : '0;
  assign mem_wstrb  = mem_req ? entries[head].wstrb : '0;
  assign fence_done = fence_req && (count == '0) && (state == IDLE);

  logic [DEPTH-1:0] hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = entries[i].valid &&
                    (entries[i].addr[ADDR_W-1:3] == ld_addr[ADDR_W-1:3]);
  end
  assign ld_conflict = |hit;

  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[2:0];

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer; inputs change and outputs are
// sampled on the falling clock edge.
module tb_store_commit_buffer;

  logic        clk, reset;
  logic        st_valid;
  logic [63:0] st_addr, st_data;
  logic [3:0]  st_size;
  logic        retire_stall, mem_req, mem_ack;
  logic [63:0] mem_addr, mem_wdata, ld_addr;
  logic [7:0]  mem_wstrb;
  logic        ld_conflict, fence_req, fence_done, misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  store_commit_buffer #(.DEPTH(8), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .retire_stall(retire_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .fence_req(fence_req), .fence_done(fence_done),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic drive_st(input logic v, input logic [63:0] a, input logic [63:0] d,
                          input logic [3:0] s);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  initial begin
    logic [63:0] e;
    reset = 1'b0; mem_ack = 1'b0; ld_addr = '0; fence_req = 1'b0;
    drive_st(0, 0, 0, 0);
    cyc; cyc;
    chk("rst_req",     mem_req, 0);
    chk("rst_stall",   retire_stall, 0);
    chk("rst_mis",     misalign_err, 0);
    chk("rst_fence",   fence_done, 0);
    chk("rst_ldc",     ld_conflict, 0);
    chk("rst_wstrb",   mem_wstrb, 0);
    reset = 1'b1;
    cyc;

    // 1: single SW, ack two cycles after the request rises
    drive_st(1, 64'h1004, 64'hDEADBEEF, 4'd4); cyc;
    drive_st(0, 0, 0, 0);
    chk("t1_lat", mem_req, 0); cyc;
    chk("t1_req",   mem_req, 1);
    chk("t1_addr",  mem_addr, 64'h1000);
    chk("t1_wstrb", mem_wstrb, 8'hF0);
    chk("t1_wdata", mem_wdata, 64'hDEADBEEF_00000000); cyc;
    chk("t1_hreq",  mem_req, 1);
    chk("t1_haddr", mem_addr, 64'h1000);
    chk("t1_hdata", mem_wdata, 64'hDEADBEEF_00000000);
    mem_ack = 1'b1; cyc;
    mem_ack = 1'b0;
    chk("t1_done", mem_req, 0);

    // 2: fill to DEPTH with no acks, 9th push ignored, then drain
    for (int i = 0; i < 8; i++) begin
      chk("t2_nostall", retire_stall, 0);
      drive_st(1, 64'h2000 + 64'(8 * i), 64'(i + 1), 4'd8); cyc;
    end
    chk("t2_stall", retire_stall, 1);
    drive_st(1, 64'h3000, 64'h99, 4'd8); cyc;
    drive_st(0, 0, 0, 0);
    chk("t2_stall_hold", retire_stall, 1);
    mem_ack = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("t2_req",   mem_req, 1);
      chk("t2_addr",  mem_addr, 64'h2000 + 64'(8 * j));
      chk("t2_data",  mem_wdata, 64'(j + 1));
      chk("t2_stall_drop", retire_stall, 64'(j == 0));
      cyc;
    end
    mem_ack = 1'b0;
    chk("t2_empty", mem_req, 0);

    // 3: ack held high, four byte stores drain back-to-back
    mem_ack = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive_st(1, 64'h20 + 64'(c), 64'hA0 + 64'(c), 4'd1);
      else       drive_st(0, 0, 0, 0);
      if (c < 2 || c == 6) chk("t3_idle", mem_req, 0);
      else begin
        e = (64'hA0 + 64'(c - 2)) << (8 * (c - 2));
        chk("t3_req",   mem_req, 1);
        chk("t3_addr",  mem_addr, 64'h20);
        chk("t3_wstrb", mem_wstrb, 64'(8'h01 << (c - 2)));
        chk("t3_wdata", mem_wdata, e);
      end
      cyc;
    end
    mem_ack = 1'b0;

    // 4: load conflict against pending and in-flight SD
    drive_st(1, 64'h100, 64'h1122334455667788, 4'd8); cyc;
    drive_st(0, 0, 0, 0);
    ld_addr = 64'h104; #1 chk("t4_hit", ld_conflict, 1);
    ld_addr = 64'h108; #1 chk("t4_miss_hi", ld_conflict, 0);
    ld_addr = 64'hF8;  #1 chk("t4_miss_lo", ld_conflict, 0);
    cyc;
    ld_addr = 64'h104; #1 chk("t4_inflight", ld_conflict, 1);
    chk("t4_req", mem_req, 1);
    mem_ack = 1'b1; cyc;
    mem_ack = 1'b0;
    #1 chk("t4_after_ack", ld_conflict, 0);

    // 5: misaligned SH pulses error; illegal size silently dropped
    drive_st(1, 64'h3, 64'hBEEF, 4'd2); cyc;
    chk("t5_mis", misalign_err, 1);
    drive_st(1, 64'h40, 64'h1234, 4'd3); cyc;
    drive_st(0, 0, 0, 0);
    chk("t5_mis_clr", misalign_err, 0);
    chk("t5_noreq0", mem_req, 0); cyc;
    chk("t5_noreq1", mem_req, 0);
    ld_addr = 64'h0;  #1 chk("t5_ld0", ld_conflict, 0);
    ld_addr = 64'h40; #1 chk("t5_ld40", ld_conflict, 0);

    // 6: fence waits for three drains; reset abandons an in-flight request
    fence_req = 1'b1;
    #1 chk("t6_fence_empty", fence_done, 1);
    for (int i = 0; i < 3; i++) begin
      drive_st(1, 64'h500 + 64'(8 * i), 64'(i), 4'd8); cyc;
      chk("t6_fence_busy", fence_done, 0);
    end
    drive_st(0, 0, 0, 0);
    mem_ack = 1'b1;
    for (int c = 3; c < 7; c++) begin
      chk("t6_fence", fence_done, 64'(c == 6));
      cyc;
    end
    mem_ack = 1'b0;
    drive_st(1, 64'h600, 64'h77, 4'd8); cyc;
    drive_st(0, 0, 0, 0); cyc;
    chk("t6_req", mem_req, 1);
    reset = 1'b0; cyc;
    chk("t6_rst_req",   mem_req, 0);
    chk("t6_rst_empty", fence_done, 1);
    chk("t6_rst_stall", retire_stall, 0);
    ld_addr = 64'h600; #1 chk("t6_rst_ldc", ld_conflict, 0);
    reset = 1'b1; cyc;
    chk("t6_post_rst", mem_req, 0);
    fence_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
